matmul_sequencer: RTL and testbench
===================================

# matmul_sequencer

Control-and-datapath stage that sits directly on the matrix memory's ports and drives them. On a start pulse it reads operand matrices A and B element by element, multiply-accumulates each dot product, and writes result matrix C back into the same memory. It turns the passive storage block into a complete matrix multiplier with a start/done handshake toward the top level.

## Interface
Parameters:
- `N`, 2, matrix dimension; A, B and C are all N×N, with 1 ≤ N ≤ 8.
- `SIZE`, 8, element width in bits; matches the memory word width.
- `A_BASE`, 0, memory address of A[0][0]; A is stored row-major.
- `B_BASE`, N*N, memory address of B[0][0]; B is stored row-major.
- `C_BASE`, 2*N*N, memory address of C[0][0]; C is written row-major.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  request to begin a multiply; sampled only in IDLE.
- `busy`  out  1  high from the cycle after start is accepted until DONE.
- `done`  out  1  one-cycle pulse when C is completely written.
- `ovf`  out  1  sticky flag: some C element exceeded 2^SIZE−1.
- `read`  out  1  memory read strobe.
- `read_address0`  out  8  address of the A element.
- `read_address1`  out  8  address of the B element.
- `data0`  in  SIZE  A element; valid the cycle after `read`.
- `data1`  in  SIZE  B element; valid the cycle after `read`.
- `write`  out  1  memory write strobe.
- `write_address0`  out  8  address of the C element.
- `write_value0`  out  SIZE  value of the C element.

## Operation
- FSM states: IDLE, READ, MAC, WRITE, DONE.
- IDLE:
  - If `start` is high, clear i, j, k, the accumulator and `ovf`, then go to READ.
  - Otherwise stay in IDLE.
- READ:
  - Assert `read` for one cycle.
  - `read_address0` = A_BASE + i*N + k.
  - `read_address1` = B_BASE + k*N + j.
  - Next state: MAC.
- MAC:
  - acc ← acc + data0*data1. Operands are unsigned.
  - The accumulator is 2*SIZE + clog2(N) bits wide and never wraps internally.
  - If k < N−1: increment k, go to READ.
  - Otherwise: go to WRITE.
- WRITE:
  - Assert `write` for one cycle.
  - `write_address0` = C_BASE + i*N + j.
  - `write_value0` = acc[SIZE−1:0].
  - Set `ovf` if acc ≥ 2^SIZE.
  - Clear acc and k, then advance j, wrapping into i.
  - If i = j = N−1 was just written, go to DONE; otherwise go to READ.
- DONE: assert `done` for one cycle, then go to IDLE.
- A `start` pulse while busy or in DONE is ignored and is not queued.
- `read` and `write` are never high in the same cycle.
- The block issues addresses exactly as computed above and applies no offset; any offset is the memory's concern.
- The address sum must fit in 8 bits. Instantiation rejects any parameter set with C_BASE + N*N > 256.

## Timing
- Reset values: IDLE state; busy, done, ovf, read and write all 0; all addresses and write_value0 equal 0; acc, i, j and k equal 0.
- Reset asserted mid-operation returns to IDLE on the next edge. No further read or write is issued, and the partially written C is left as is.
- Per C element: N READ/MAC pairs plus one WRITE, i.e. 2N+1 cycles.
- `start` sampled at edge 0 gives:
  - `busy` high from cycle 1.
  - `done` high in cycle N²(2N+1)+1; for N=2 that is cycle 21.
  - `busy` low in the same cycle `done` is high.
- Back-to-back operation: `start` can be accepted in the IDLE cycle immediately after DONE.
- Output registering: read/write strobes, addresses and write_value0 are driven from registers, not combinationally from `start`.

## Structure
- Package `matmul_pkg` holds:
  - the FSM state enum;
  - the default SIZE and N;
  - the accumulator-width function;
  - base-address helper constants.
- Sub-module `mac_unit` contains the unsigned multiplier and accumulator, with clear, enable and overflow-compare.
- The FSM, index counters and address generation stay in the top module.

## Test plan
- **Basic multiply:** preload A=[[1,2],[3,4]] at 0..3 and B=[[5,6],[7,8]] at 4..7, pulse start → C=[[19,22],[43,50]] written at addresses 8..11 in order, done at cycle 21, ovf=0.
- **Identity:** A=[[1,0],[0,1]], B=[[9,8],[7,6]] → C=[[9,8],[7,6]], exactly 4 write strobes, 8 read strobes total.
- **Overflow:** all A and B elements = 255 → each C element = 130050, written as 2, ovf=1 after the first WRITE and still 1 after done. The next start clears ovf.
- **Start ignored while busy:** pulse start again at cycle 5 → no restart, done still at cycle 21, still only 4 writes.
- **Reset mid-operation:** assert rst at cycle 7 → next cycle shows state IDLE, busy=0, no write afterwards, C[0][0] already written stays 19.
- **Zero matrices:** all-zero A and B → C all 0, ovf=0. A start in the cycle after done is accepted and produces done again at +21 cycles.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply sequencer: FSM states,
// default geometry, accumulator sizing and row-major address helpers.
package matmul_pkg;

  localparam int DEFAULT_N    = 2;
  localparam int DEFAULT_SIZE = 8;
  localparam int ADDR_W       = 8;
  localparam int IDX_W        = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_MAC,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Wide enough that N full-scale products summed together never wrap.
  function automatic int acc_width(input int size, input int n);
    return 2 * size + $clog2(n);
  endfunction

  function automatic int b_base_of(input int n);
    return n * n;
  endfunction

  function automatic int c_base_of(input int n);
    return 2 * n * n;
  endfunction

  function automatic logic [ADDR_W-1:0] elem_addr(input int base,
                                                  input logic [IDX_W-1:0] row,
                                                  input logic [IDX_W-1:0] col,
                                                  input int n);
    return ADDR_W'(base + int'(row) * n + int'(col));
  endfunction

endpackage

// File: rtl/matmul_mac_unit.sv
// Unsigned multiply-accumulate with synchronous clear, enable and a flag
// telling whether the running sum no longer fits in one memory word.
module mac_unit #(
  parameter int SIZE  = 8,
  parameter int ACC_W = 17
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] result_next,
  output logic            ovf
);

  logic [2*SIZE-1:0] product;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;

  assign product = (2*SIZE)'(a) * (2*SIZE)'(b);

  // Clear wins over enable so a WRITE cycle always starts the next element at 0.
  always_comb begin
    acc_next = acc;
    if (clr) begin
      acc_next = '0;
    end else if (en) begin
      acc_next = acc + ACC_W'(product);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else begin
      acc <= acc_next;
    end
  end

  assign result_next = acc_next[SIZE-1:0];
  assign ovf         = |acc[ACC_W-1:SIZE];

endmodule

// File: rtl/matmul_sequencer.sv
// Drives the matrix memory ports: reads A and B element by element,
// accumulates each dot product and writes C back, with a start/done handshake.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int SIZE   = DEFAULT_SIZE,
  parameter int A_BASE = 0,
  parameter int B_BASE = b_base_of(N),
  parameter int C_BASE = c_base_of(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              read,
  output logic [ADDR_W-1:0] read_address0,
  output logic [ADDR_W-1:0] read_address1,
  input  logic [SIZE-1:0]   data0,
  input  logic [SIZE-1:0]   data1,
  output logic              write,
  output logic [ADDR_W-1:0] write_address0,
  output logic [SIZE-1:0]   write_value0
);

  localparam int ACC_W = acc_width(SIZE, N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  if (N < 1 || N > 8 || C_BASE + N * N > 256) begin : g_bad_params
    $error("matmul_sequencer: N must be 1..8 and C_BASE + N*N must not exceed 256");
  end

  state_t           state, state_next;
  logic [IDX_W-1:0] i, j, k;
  logic [IDX_W-1:0] i_next, j_next, k_next;
  logic             acc_clr, acc_en;
  logic             acc_ovf;
  logic [SIZE-1:0]  result_next;

  mac_unit #(
    .SIZE  (SIZE),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk         (clk),
    .rst         (rst),
    .clr         (acc_clr),
    .en          (acc_en),
    .a           (data0),
    .b           (data1),
    .result_next (result_next),
    .ovf         (acc_ovf)
  );

  // Index walk: k over the dot product, then j across a row, then i down rows.
  always_comb begin
    state_next = state;
    i_next     = i;
    j_next     = j;
    k_next     = k;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          i_next     = '0;
          j_next     = '0;
          k_next     = '0;
          acc_clr    = 1'b1;
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        state_next = ST_MAC;
      end
      ST_MAC: begin
        acc_en = 1'b1;
        if (k != LAST) begin
          k_next     = k + 1'b1;
          state_next = ST_READ;
        end else begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        acc_clr    = 1'b1;
        k_next     = '0;
        state_next = ST_READ;
        if (j != LAST) begin
          j_next = j + 1'b1;
        end else begin
          j_next = '0;
          if (i != LAST) begin
            i_next = i + 1'b1;
          end else begin
            i_next     = '0;
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Strobes, addresses and the write value are registered from the next-state
  // view so they line up with the state they belong to without any decode glue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      i              <= '0;
      j              <= '0;
      k              <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      ovf            <= 1'b0;
      read           <= 1'b0;
      write          <= 1'b0;
      read_address0  <= '0;
      read_address1  <= '0;
      write_address0 <= '0;
      write_value0   <= '0;
    end else begin
      state <= state_next;
      i     <= i_next;
      j     <= j_next;
      k     <= k_next;
      busy  <= (state_next == ST_READ) || (state_next == ST_MAC) || (state_next == ST_WRITE);
      done  <= (state_next == ST_DONE);
      read  <= (state_next == ST_READ);
      write <= (state_next == ST_WRITE);
      if (state_next == ST_READ) begin
        read_address0 <= elem_addr(A_BASE, i_next, k_next, N);
        read_address1 <= elem_addr(B_BASE, k_next, j_next, N);
      end
      if (state_next == ST_WRITE) begin
        write_address0 <= elem_addr(C_BASE, i_next, j_next, N);
        write_value0   <= result_next;
      end
      if (state == ST_IDLE && start) begin
        ovf <= 1'b0;
      end else if (state == ST_WRITE && acc_ovf) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer (N=2, SIZE=8): models the memory,
// logs every write and checks results, timing and handshake behaviour.
module tb_matmul_sequencer;
  import matmul_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, ovf, read, write;
  logic [7:0] read_address0, read_address1, write_address0, write_value0;
  logic [7:0] data0 = '0;
  logic [7:0] data1 = '0;

  logic [7:0] mem [256];
  logic [7:0] wr_addr [64];
  logic [7:0] wr_val [64];
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  int         both_cnt = 0;
  int         cyc = 0;

  int   checks = 0;
  int   errors = 0;
  int   r_done_at, r_rds, r_wrs, r_base_wr;
  logic r_ovf_c6, r_busy_c1, r_busy_done;

  matmul_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .ovf            (ovf),
    .read           (read),
    .read_address0  (read_address0),
    .read_address1  (read_address1),
    .data0          (data0),
    .data1          (data1),
    .write          (write),
    .write_address0 (write_address0),
    .write_value0   (write_value0)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, writes captured into a log.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (read) begin
      data0  <= mem[read_address0];
      data1  <= mem[read_address1];
      rd_cnt <= rd_cnt + 1;
    end
    if (write) begin
      wr_addr[wr_cnt % 64] <= write_address0;
      wr_val[wr_cnt % 64]  <= write_value0;
      wr_cnt <= wr_cnt + 1;
    end
    if (read && write) both_cnt <= both_cnt + 1;
  end

  task automatic load(input logic [31:0] a, input logic [31:0] b);
    for (int e = 0; e < 4; e++) begin
      mem[e]     = a[8*e +: 8];
      mem[4 + e] = b[8*e +: 8];
    end
  endtask

  // Starts one operation (cycle 1 = first cycle after the start edge) and
  // waits a bounded time for done; optionally re-pulses start in a given cycle.
  task automatic run_op(input int extra_start_at);
    int s, n, base_rd;
    base_rd     = rd_cnt;
    r_base_wr   = wr_cnt;
    r_done_at   = -1;
    r_ovf_c6    = 1'bx;
    r_busy_c1   = 1'bx;
    r_busy_done = 1'bx;
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 100; t++) begin
      n = cyc - s;
      if (n == 1) r_busy_c1 = busy;
      if (n == 6) r_ovf_c6 = ovf;
      if (done === 1'b1) begin
        r_done_at   = n;
        r_busy_done = busy;
        break;
      end
      start = (n == extra_start_at);
      @(negedge clk);
    end
    start = 1'b0;
    r_rds = rd_cnt - base_rd;
    r_wrs = wr_cnt - r_base_wr;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("[TB] FAIL reset_state: got %0d expected %0d", dut.state, ST_IDLE); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (read !== 1'b0) begin errors++; $display("[TB] FAIL reset_read: got %b expected 0", read); end
    checks++; if (write !== 1'b0) begin errors++; $display("[TB] FAIL reset_write: got %b expected 0", write); end
    checks++; if (read_address1 !== 8'd0) begin errors++; $display("[TB] FAIL reset_raddr1: got %0d expected 0", read_address1); end
    checks++; if (write_address0 !== 8'd0) begin errors++; $display("[TB] FAIL reset_waddr: got %0d expected 0", write_address0); end
    checks++; if (write_value0 !== 8'd0) begin errors++; $display("[TB] FAIL reset_wval: got %0d expected 0", write_value0); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_start_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic_multiply;
    logic [31:0] exp_c;
    exp_c = {8'd50, 8'd43, 8'd22, 8'd19};
    load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
    run_op(-1);
    checks++; if (r_done_at !== 21) begin errors++; $display("[TB] FAIL basic_done_cycle: got %0d expected 21", r_done_at); end
    checks++; if (r_busy_c1 !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_c1: got %b expected 1", r_busy_c1); end
    checks++; if (r_busy_done !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_at_done: got %b expected 0", r_busy_done); end
    checks++; if (r_wrs !== 4) begin errors++; $display("[TB] FAIL basic_writes: got %0d expected 4", r_wrs); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf: got %b expected 0", ovf); end
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (wr_addr[(r_base_wr + e) % 64] !== 8'(8 + e)) begin
        errors++; $display("[TB] FAIL basic_addr%0d: got %0d expected %0d", e, wr_addr[(r_base_wr + e) % 64], 8 + e);
      end
      checks++;
      if (wr_val[(r_base_wr + e) % 64] !== exp_c[8*e +: 8]) begin
        errors++; $display("[TB] FAIL basic_c%0d: got %0d expected %0d", e, wr_val[(r_base_wr + e) % 64], exp_c[8*e +: 8]);
      end
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_identity;
    logic [31:0] exp_c;
    exp_c = {8'd6, 8'd7, 8'd8, 8'd9};
    load({8'd1, 8'd0, 8'd0, 8'd1}, {8'd6, 8'd7, 8'd8, 8'd9});
    run_op(-1);
    checks++; if (r_wrs !== 4) begin errors++; $display("[TB] FAIL ident_writes: got %0d expected 4", r_wrs); end
    checks++; if (r_rds !== 8) begin errors++; $display("[TB] FAIL ident_reads: got %0d expected 8", r_rds); end
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (wr_val[(r_base_wr + e) % 64] !== exp_c[8*e +: 8]) begin
        errors++; $display("[TB] FAIL ident_c%0d: got %0d expected %0d", e, wr_val[(r_base_wr + e) % 64], exp_c[8*e +: 8]);
      end
    end
  endtask

  task automatic test_overflow;
    load(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(-1);
    checks++; if (r_ovf_c6 !== 1'b1) begin errors++; $display("[TB] FAIL ovf_after_first_write: got %b expected 1", r_ovf_c6); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_at_done: got %b expected 1", ovf); end
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (wr_val[(r_base_wr + e) % 64] !== 8'd2) begin
        errors++; $display("[TB] FAIL ovf_c%0d: got %0d expected 2", e, wr_val[(r_base_wr + e) % 64]);
      end
    end
    @(negedge clk);
    checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky_idle: got %b expected 1", ovf); end
  endtask

  task automatic test_start_ignored;
    load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
    run_op(5);
    checks++; if (r_ovf_c6 !== 1'b0) begin errors++; $display("[TB] FAIL ign_ovf_cleared: got %b expected 0", r_ovf_c6); end
    checks++; if (r_done_at !== 21) begin errors++; $display("[TB] FAIL ign_done_cycle: got %0d expected 21", r_done_at); end
    checks++; if (r_wrs !== 4) begin errors++; $display("[TB] FAIL ign_writes: got %0d expected 4", r_wrs); end
    checks++; if (wr_val[(r_base_wr + 3) % 64] !== 8'd50) begin errors++; $display("[TB] FAIL ign_c3: got %0d expected 50", wr_val[(r_base_wr + 3) % 64]); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ign_not_queued: got busy %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_op;
    int base;
    load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
    base = wr_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("[TB] FAIL rstmid_state: got %0d expected %0d", dut.state, ST_IDLE); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (read !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_read: got %b expected 0", read); end
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (wr_cnt - base !== 1) begin errors++; $display("[TB] FAIL rstmid_writes: got %0d expected 1", wr_cnt - base); end
    checks++; if (wr_val[base % 64] !== 8'd19) begin errors++; $display("[TB] FAIL rstmid_c00: got %0d expected 19", wr_val[base % 64]); end
  endtask

  task automatic test_back_to_back;
    load(32'h0, 32'h0);
    run_op(-1);
    checks++; if (r_done_at !== 21) begin errors++; $display("[TB] FAIL zero_done_cycle: got %0d expected 21", r_done_at); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL zero_ovf: got %b expected 0", ovf); end
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (wr_val[(r_base_wr + e) % 64] !== 8'd0) begin
        errors++; $display("[TB] FAIL zero_c%0d: got %0d expected 0", e, wr_val[(r_base_wr + e) % 64]);
      end
    end
    run_op(-1);
    checks++; if (r_done_at !== 21) begin errors++; $display("[TB] FAIL b2b_done_cycle: got %0d expected 21", r_done_at); end
    checks++; if (r_wrs !== 4) begin errors++; $display("[TB] FAIL b2b_writes: got %0d expected 4", r_wrs); end
    checks++; if (both_cnt !== 0) begin errors++; $display("[TB] FAIL read_write_overlap: got %0d expected 0", both_cnt); end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = '0;
    test_reset();
    test_basic_multiply();
    test_identity();
    test_overflow();
    test_start_ignored();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
